alu_seq: RTL and testbench

//  Parametrised, handshaked successor to the execute-stage ALU. Adds logic/shift ops and an

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_mul_iter.sv | 84 ++++++++
 rtl/alu_seq.sv | 148 ++++++++++++++
 tb/tb_alu_seq.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_LI   = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd10;
    localparam logic [ALU_OP_W-1:0] ALU_MUL  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_HOLD     = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_BPC bits of B per cycle.
// With ALU_SEQ_OVF_EN the full 2*WIDTH product is kept and signed-corrected for ovf.
module alu_mul_iter #(
    parameter int WIDTH   = 48,
    parameter int MUL_BPC = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef ALU_SEQ_OVF_EN
    output logic             ovf,
`endif
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int STEPS = WIDTH / MUL_BPC;
    localparam int CNT_W = $clog2(STEPS + 1);
`ifdef ALU_SEQ_OVF_EN
    localparam int ACC_W = 2 * WIDTH;
`else
    localparam int ACC_W = WIDTH;
`endif

    logic [ACC_W-1:0] a_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] pp;
    logic [WIDTH-1:0] b_q;
    logic [CNT_W-1:0] cnt_q;

    assign done  = (cnt_q == CNT_W'(1));
    assign pp    = a_q * ACC_W'(b_q[MUL_BPC-1:0]);
    assign acc_d = acc_q + pp;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            a_q   <= ACC_W'(a);
            b_q   <= b;
            acc_q <= '0;
            cnt_q <= CNT_W'(STEPS);
        end else if (cnt_q != '0) begin
            a_q   <= a_q << MUL_BPC;
            b_q   <= b_q >> MUL_BPC;
            acc_q <= acc_d;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

`ifdef ALU_SEQ_OVF_EN
    logic [WIDTH-1:0] a_orig_q;
    logic [WIDTH-1:0] b_orig_q;
    logic [ACC_W-1:0] corr;
    logic [ACC_W-1:0] signed_prod;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_orig_q <= '0;
            b_orig_q <= '0;
        end else if (start) begin
            a_orig_q <= a;
            b_orig_q <= b;
        end
    end

    // Unsigned product minus 2^WIDTH * (other operand) for each negative operand.
    assign corr = (a_orig_q[WIDTH-1] ? {b_orig_q, {WIDTH{1'b0}}} : '0)
                + (b_orig_q[WIDTH-1] ? {a_orig_q, {WIDTH{1'b0}}} : '0);
    assign signed_prod = acc_d - corr;
    assign product     = signed_prod[WIDTH-1:0];
    assign ovf = (signed_prod[ACC_W-1:WIDTH-1] != '0) &&
                 (signed_prod[ACC_W-1:WIDTH-1] != '1);
`else
    assign product = acc_d;
`endif

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU with single-cycle ops and an iterative MUL.
// Optional signed-overflow output enabled by defining ALU_SEQ_OVF_EN.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 48,
    parameter int MUL_BPC = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [WIDTH-1:0]    operand1,
    input  logic [WIDTH-1:0]    operand2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result,
    output logic                zero,
`ifdef ALU_SEQ_OVF_EN
    output logic                ovf,
`endif
    output state_t              state_dbg
);

    // Handshake: a transfer happens on any rising edge where valid && ready are both high;
    // valid never waits on ready, and the result is held unchanged until it is accepted.

    localparam int SH_W = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic             load_alu;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SH_W-1:0]  shamt;

    assign sum   = operand1 + operand2;
    assign diff  = operand1 - operand2;
    assign shamt = operand2[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:  alu_res = sum;
            ALU_SUB:  alu_res = diff;
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(operand1) < $signed(operand2)};
            ALU_LI:   alu_res = operand2;
            ALU_AND:  alu_res = operand1 & operand2;
            ALU_OR:   alu_res = operand1 | operand2;
            ALU_XOR:  alu_res = operand1 ^ operand2;
            ALU_SLL:  alu_res = operand1 << shamt;
            ALU_SRL:  alu_res = operand1 >> shamt;
            ALU_SRA:  alu_res = $signed(operand1) >>> shamt;
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, operand1 < operand2};
            default:  alu_res = '0;
        endcase
    end

`ifdef ALU_SEQ_OVF_EN
    logic alu_ovf;
    logic mul_ovf;

    always_comb begin
        alu_ovf = 1'b0;
        if (alu_op == ALU_ADD)
            alu_ovf = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                      (sum[WIDTH-1] != operand1[WIDTH-1]);
        else if (alu_op == ALU_SUB)
            alu_ovf = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                      (diff[WIDTH-1] != operand1[WIDTH-1]);
    end
`endif

    alu_mul_iter #(
        .WIDTH   (WIDTH),
        .MUL_BPC (MUL_BPC)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (operand1),
        .b       (operand2),
`ifdef ALU_SEQ_OVF_EN
        .ovf     (mul_ovf),
`endif
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        load_alu  = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE:     in_ready = 1'b1;
            ST_MUL_BUSY: if (mul_done) state_d = ST_HOLD;
            ST_HOLD: begin
                in_ready = out_ready;
                if (out_ready) state_d = ST_IDLE;
            end
            default:     state_d = ST_IDLE;
        endcase
        if (in_valid && in_ready) begin
            if (alu_op == ALU_MUL) begin
                mul_start = 1'b1;
                state_d   = ST_MUL_BUSY;
            end else begin
                load_alu  = 1'b1;
                state_d   = ST_HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            result  <= '0;
            zero    <= 1'b1;
`ifdef ALU_SEQ_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (load_alu) begin
                result <= alu_res;
                zero   <= (alu_res == '0);
`ifdef ALU_SEQ_OVF_EN
                ovf    <= alu_ovf;
`endif
            end else if (state_q == ST_MUL_BUSY && mul_done) begin
                result <= mul_product;
                zero   <= (mul_product == '0);
`ifdef ALU_SEQ_OVF_EN
                ovf    <= mul_ovf;
`endif
            end
        end
    end

    assign out_valid = (state_q == ST_HOLD);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus randomized traffic vs. a reference model.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W   = 48;
    localparam int BPC = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   alu_op = '0;
    logic [W-1:0] operand1 = '0;
    logic [W-1:0] operand2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero;
    logic         ovf;
    state_t       state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W:0] exp_q[$];

    alu_seq #(.WIDTH(W), .MUL_BPC(BPC)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .operand1  (operand1),
        .operand2  (operand2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
`ifdef ALU_SEQ_OVF_EN
        .ovf       (ovf),
`endif
        .state_dbg (state_dbg)
    );

`ifndef ALU_SEQ_OVF_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        alu_op   = op;
        operand1 = a;
        operand2 = b;
    endtask

    // Reference model: returns {signed_overflow, result} from the opcode's arithmetic meaning.
    function automatic logic [W:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        logic signed [2*W-1:0] sa, sb, full, lim;
        logic [W-1:0] r;
        logic         ov;
        int           sh;
        sa  = $signed(a);
        sb  = $signed(b);
        lim = 1;
        lim = lim <<< (W - 1);
        sh  = int'(b) & 63;
        r   = '0;
        ov  = 1'b0;
        full = '0;
        case (op)
            4'd0:  begin full = sa + sb; r = full[W-1:0]; ov = (full >= lim) || (full < -lim); end
            4'd1:  begin full = sa - sb; r = full[W-1:0]; ov = (full >= lim) || (full < -lim); end
            4'd2:  r = (sa < sb) ? 1 : 0;
            4'd3:  r = b;
            4'd4:  r = a & b;
            4'd5:  r = a | b;
            4'd6:  r = a ^ b;
            4'd7:  r = (sh >= W) ? '0 : a << sh;
            4'd8:  r = (sh >= W) ? '0 : a >> sh;
            4'd9:  begin full = sa >>> sh; r = full[W-1:0]; end
            4'd10: r = (a < b) ? 1 : 0;
            4'd11: begin full = sa * sb; r = full[W-1:0]; ov = (full >= lim) || (full < -lim); end
            default: r = '0;
        endcase
        return {ov, r};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_checks++;
        if (result !== '0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
        n_checks++;
        if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got %0b want 1", zero); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
`ifdef ALU_SEQ_OVF_EN
        n_checks++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", ovf); end
`endif
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        offer(ALU_ADD, 5, 7);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || result !== 48'd12 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL add_5_7 got v=%0b r=%0d z=%0b want v=1 r=12 z=0", out_valid, result, zero);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain got v=%0b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]   ops[3];
        logic [W-1:0] as[3];
        logic [W-1:0] bs[3];
        logic [W-1:0] exp_r[3];
        ops = '{ALU_SUB, ALU_SLT, ALU_SRA};
        as  = '{48'd3, {W{1'b1}}, 48'h8000_0000_0000};
        bs  = '{48'd3, 48'd1, 48'd4};
        exp_r = '{48'd0, 48'd1, 48'hF800_0000_0000};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(ops[i], as[i], bs[i]);
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || result !== exp_r[i] || zero !== (exp_r[i] == '0)) begin
                n_fail++;
                $display("FAIL b2b_%0d got v=%0b r=%h z=%0b want v=1 r=%h", i, out_valid, result, zero, exp_r[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got v=%0b want 0", out_valid); end
    endtask

    task automatic test_mul_stall();
        out_ready = 1'b1;
        offer(ALU_MUL, 48'd1234, 48'd5678);
        tick();
        offer(ALU_ADD, 48'd10, 48'd20);
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mul_busy_cyc%0d got rdy=%0b v=%0b want rdy=0 v=0", i, in_ready, out_valid);
            end
            if (i < 11) tick();
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || result !== 48'd7006652 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_result got v=%0b r=%0d rdy=%0b want v=1 r=7006652 rdy=1", out_valid, result, in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || result !== 48'd30) begin
            n_fail++;
            $display("FAIL mul_then_add got v=%0b r=%0d want v=1 r=30", out_valid, result);
        end
        tick();
    endtask

    task automatic test_out_stall();
        out_ready = 1'b0;
        offer(ALU_ADD, 48'd1, 48'd1);
        tick();
        offer(ALU_SUB, 48'd9, 48'd4);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || result !== 48'd2 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_cyc%0d got v=%0b r=%0d rdy=%0b want v=1 r=2 rdy=0", i, out_valid, result, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_rdy got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || result !== 48'd5) begin
            n_fail++;
            $display("FAIL stall_second_op got v=%0b r=%0d want v=1 r=5", out_valid, result);
        end
        tick();
    endtask

    task automatic test_reset_mid_mul();
        out_ready = 1'b1;
        offer(ALU_MUL, 48'd77777, 48'd99999);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || result !== '0 || zero !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midmul_reset got v=%0b r=%h z=%0b rdy=%0b want v=0 r=0 z=1 rdy=1", out_valid, result, zero, in_ready);
        end
        offer(ALU_ADD, 48'd2, 48'd2);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || result !== 48'd4) begin
            n_fail++;
            $display("FAIL midmul_add got v=%0b r=%0d want v=1 r=4", out_valid, result);
        end
        for (int i = 0; i < 14; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midmul_ghost_cyc%0d got v=%0b want 0", i, out_valid); end
        end
    endtask

`ifdef ALU_SEQ_OVF_EN
    task automatic test_ovf();
        logic [3:0]   ops[3];
        logic [W-1:0] as[3];
        logic [W-1:0] bs[3];
        logic [W-1:0] exp_r[3];
        logic         exp_o[3];
        ops = '{ALU_ADD, ALU_SUB, 4'd15};
        as  = '{48'h7FFF_FFFF_FFFF, 48'd0, 48'd123};
        bs  = '{48'd1, 48'd1, 48'd456};
        exp_r = '{48'h8000_0000_0000, {W{1'b1}}, 48'd0};
        exp_o = '{1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(ops[i], as[i], bs[i]);
            tick();
            n_checks++;
            if (result !== exp_r[i] || ovf !== exp_o[i] || zero !== (exp_r[i] == '0)) begin
                n_fail++;
                $display("FAIL ovf_%0d got r=%h o=%0b z=%0b want r=%h o=%0b", i, result, ovf, zero, exp_r[i], exp_o[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask
`endif

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return {W{1'b1}};
            2: return {1'b0, {(W-1){1'b1}}};
            3: return {1'b1, {(W-1){1'b0}}};
            4: return W'($urandom_range(0, 300));
            default: return W'({$urandom(), $urandom()});
        endcase
    endfunction

    task automatic test_random();
        logic [W:0] e;
        logic       acc, hs;
        exp_q.delete();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            alu_op    = ($urandom_range(0, 3) == 0) ? ALU_MUL : 4'($urandom_range(0, 15));
            operand1  = rand_operand();
            operand2  = rand_operand();
            #1;
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_spurious cyc%0d got r=%h want no result", cyc, result);
                end else begin
                    e = exp_q[0];
                    if (result !== e[W-1:0] || zero !== (e[W-1:0] == '0)
`ifdef ALU_SEQ_OVF_EN
                        || ovf !== e[W]
`endif
                    ) begin
                        n_fail++;
                        $display("FAIL rand_result cyc%0d got r=%h z=%0b o=%0b want r=%h o=%0b",
                                 cyc, result, zero, ovf, e[W-1:0], e[W]);
                    end
                    if (hs) void'(exp_q.pop_front());
                end
            end
            if (acc) exp_q.push_back(model(alu_op, operand1, operand2));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            #1;
            if (out_valid) begin
                e = exp_q.pop_front();
                n_checks++;
                if (result !== e[W-1:0]) begin
                    n_fail++;
                    $display("FAIL rand_drain got r=%h want r=%h", result, e[W-1:0]);
                end
            end
            tick();
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_timeout got %0d pending want 0", exp_q.size());
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_add();
        test_back_to_back();
        test_mul_stall();
        test_out_stall();
        test_reset_mid_mul();
`ifdef ALU_SEQ_OVF_EN
        test_ovf();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
